// File: rtl/mem_bus_pkg.sv
// Shared definitions for the CPU-port to SRAM-like bus bridge.
//   state_e   : bridge transaction state (IDLE/ADDR/DATA/DONE)
//   SZ_*      : bus size encodings, log2 of the transfer size in bytes
//   be_info_t : decoded byte-enable pattern (legal flag, size, low address bits)
//   be2size   : byte-enable pattern -> be_info_t for a bus of be_w byte lanes
package mem_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    localparam logic [1:0] SZ_BYTE  = 2'd0;
    localparam logic [1:0] SZ_HALF  = 2'd1;
    localparam logic [1:0] SZ_WORD  = 2'd2;
    localparam logic [1:0] SZ_DWORD = 2'd3;

    typedef struct packed {
        logic       legal;
        logic [1:0] size;
        logic [2:0] low;
    } be_info_t;

    // wen is zero-extended to 8 lanes; be_w is the real lane count (4 or 8).
    // All-zero wen is a full-width read. A write must be a contiguous run of
    // 1/2/4/8 lanes, no wider than the bus, starting on a multiple of its width.
    function automatic be_info_t be2size(input logic [7:0] wen, input int be_w);
        be_info_t   r;
        int         lo;
        int         n;
        logic [8:0] run;
        r  = '0;
        lo = 0;
        n  = 0;
        for (int i = 7; i >= 0; i--) begin
            if (wen[i]) lo = i;
        end
        for (int i = 0; i < 8; i++) begin
            n = n + int'(wen[i]);
        end
        if (n == 0) begin
            r.legal = 1'b1;
            r.size  = (be_w == 8) ? SZ_DWORD : SZ_WORD;
            r.low   = 3'd0;
        end else begin
            case (n)
                1:       r.size = SZ_BYTE;
                2:       r.size = SZ_HALF;
                4:       r.size = SZ_WORD;
                default: r.size = SZ_DWORD;
            endcase
            run     = ((9'd1 << n) - 9'd1) << lo;
            r.low   = 3'(lo);
            r.legal = (n == 1 || n == 2 || n == 4 || n == 8) && (n <= be_w) &&
                      ((lo & (n - 1)) == 0) && (run == {1'b0, wen});
        end
        return r;
    endfunction

endpackage

// File: rtl/sram_like_bridge_be_decode.sv
// Combinational byte-enable decoder.
//   wen_i   : CPU byte write enables (all-zero = read)
//   legal_o : pattern is a supported access
//   size_o  : bus size encoding (log2 bytes)
//   low_o   : byte offset of the access inside the bus word
module be_decode
    import mem_bus_pkg::*;
#(
    parameter int BE_W = 4
) (
    input  logic [BE_W-1:0] wen_i,
    output logic            legal_o,
    output logic [1:0]      size_o,
    output logic [2:0]      low_o
);

    logic [7:0] wen_ext;
    be_info_t   info;

    always_comb begin
        wen_ext             = '0;
        wen_ext[BE_W-1:0]   = wen_i;
        info                = be2size(wen_ext, BE_W);
        legal_o             = info.legal;
        size_o              = info.size;
        low_o               = info.low;
    end

endmodule

// File: rtl/sram_like_bridge.sv
// Bridge from the CPU single-cycle SRAM port to a variable-latency SRAM-like bus.
// One transaction per pipeline slot; the response is held in DONE until the
// global pipeline freeze (longest_stall) drops.
//   CPU side : cpu_en, cpu_wen, cpu_addr, cpu_wdata -> cpu_rdata, stall, bad_wen
//   Pipeline : longest_stall (global freeze from the hazard unit)
//   Bus side : req, wr, size, addr, wdata -> addr_ok, data_ok, rdata
// Handshake: the address phase completes in the cycle req && addr_ok; the data
// phase completes in the first cycle data_ok is high at or after that cycle.
// Only one transaction is ever outstanding. DATA_W must be 32 or 64.
// The FSM state is held in state_q (state_e) for observation.
module sram_like_bridge
    import mem_bus_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cpu_en,
    input  logic [DATA_W/8-1:0]   cpu_wen,
    input  logic [ADDR_W-1:0]     cpu_addr,
    input  logic [DATA_W-1:0]     cpu_wdata,
    output logic [DATA_W-1:0]     cpu_rdata,
    output logic                  stall,
    input  logic                  longest_stall,
    output logic                  bad_wen,
    output logic                  req,
    output logic                  wr,
    output logic [1:0]            size,
    output logic [ADDR_W-1:0]     addr,
    output logic [DATA_W-1:0]     wdata,
    input  logic                  addr_ok,
    input  logic                  data_ok,
    input  logic [DATA_W-1:0]     rdata
);

    localparam int              BE_W     = DATA_W / 8;
    localparam logic [ADDR_W-1:0] LOW_MASK = ADDR_W'(BE_W - 1);

    state_e              state_q, state_d;
    logic                wr_q, wr_d;
    logic [1:0]          size_q, size_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;

    logic                dec_legal;
    logic [1:0]          dec_size;
    logic [2:0]          dec_low;

    be_decode #(.BE_W(BE_W)) u_be_decode (
        .wen_i   (cpu_wen),
        .legal_o (dec_legal),
        .size_o  (dec_size),
        .low_o   (dec_low)
    );

    always_comb begin
        state_d = state_q;
        wr_d    = wr_q;
        size_d  = size_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        unique case (state_q)
            ST_IDLE: begin
                if (cpu_en && dec_legal) begin
                    wr_d    = |cpu_wen;
                    size_d  = dec_size;
                    // Reads use the aligned word; writes point at the lowest enabled lane.
                    addr_d  = (cpu_addr & ~LOW_MASK) | ADDR_W'(dec_low);
                    wdata_d = cpu_wdata;
                    state_d = ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (addr_ok) begin
                    if (data_ok) begin
                        rdata_d = rdata;
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (data_ok) begin
                    rdata_d = rdata;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                // Held while the pipeline is frozen so the slot never re-issues.
                if (!longest_stall) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        req     = (state_q == ST_ADDR);
        stall   = ((state_q == ST_IDLE) && cpu_en && dec_legal) ||
                  (state_q == ST_ADDR) || (state_q == ST_DATA);
        bad_wen = (state_q == ST_IDLE) && cpu_en && !dec_legal;
    end

    assign wr        = wr_q;
    assign size      = size_q;
    assign addr      = addr_q;
    assign wdata     = wdata_q;
    assign cpu_rdata = rdata_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            wr_q    <= 1'b0;
            size_q  <= 2'd0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            wr_q    <= wr_d;
            size_q  <= size_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

endmodule

// File: tb/tb_sram_like_bridge.sv
// Bench for sram_like_bridge: one 32-bit and one 64-bit instance; sel picks
// the instance that receives traffic, the other must sit quietly in reset state.
module tb_sram_like_bridge;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Shared stimulus, steered to one instance by sel.
    logic        sel;
    logic        en;
    logic [7:0]  wen;
    logic [31:0] caddr;
    logic [63:0] cwdata;
    logic        ls;
    logic        aok;
    logic        dok;
    logic [63:0] brdata;

    logic en32, en64, aok32, aok64, dok32, dok64;
    assign en32  = en  && !sel;
    assign en64  = en  &&  sel;
    assign aok32 = aok && !sel;
    assign aok64 = aok &&  sel;
    assign dok32 = dok && !sel;
    assign dok64 = dok &&  sel;

    logic [31:0] rd32, wd32, ad32;
    logic        st32, bad32, req32, wr32;
    logic [1:0]  sz32;
    logic [63:0] rd64, wd64;
    logic [31:0] ad64;
    logic        st64, bad64, req64, wr64;
    logic [1:0]  sz64;

    sram_like_bridge #(.DATA_W(32), .ADDR_W(32)) u_dut32 (
        .clk(clk), .rst(rst), .cpu_en(en32), .cpu_wen(wen[3:0]), .cpu_addr(caddr),
        .cpu_wdata(cwdata[31:0]), .cpu_rdata(rd32), .stall(st32), .longest_stall(ls),
        .bad_wen(bad32), .req(req32), .wr(wr32), .size(sz32), .addr(ad32),
        .wdata(wd32), .addr_ok(aok32), .data_ok(dok32), .rdata(brdata[31:0])
    );

    sram_like_bridge #(.DATA_W(64), .ADDR_W(32)) u_dut64 (
        .clk(clk), .rst(rst), .cpu_en(en64), .cpu_wen(wen), .cpu_addr(caddr),
        .cpu_wdata(cwdata), .cpu_rdata(rd64), .stall(st64), .longest_stall(ls),
        .bad_wen(bad64), .req(req64), .wr(wr64), .size(sz64), .addr(ad64),
        .wdata(wd64), .addr_ok(aok64), .data_ok(dok64), .rdata(brdata)
    );

    // Uniform view of both instances.
    logic        o_req[2], o_stall[2], o_bad[2], o_wr[2];
    logic [1:0]  o_size[2];
    logic [31:0] o_addr[2];
    logic [63:0] o_wdata[2], o_rdata[2];
    always_comb begin
        o_req[0]   = req32;          o_req[1]   = req64;
        o_stall[0] = st32;           o_stall[1] = st64;
        o_bad[0]   = bad32;          o_bad[1]   = bad64;
        o_wr[0]    = wr32;           o_wr[1]    = wr64;
        o_size[0]  = sz32;           o_size[1]  = sz64;
        o_addr[0]  = ad32;           o_addr[1]  = ad64;
        o_wdata[0] = {32'd0, wd32};  o_wdata[1] = wd64;
        o_rdata[0] = {32'd0, rd32};  o_rdata[1] = rd64;
    end

    // Expected architectural outputs per instance, maintained by the driver.
    logic        m_req[2], m_stall[2], m_bad[2], m_wr[2];
    logic [1:0]  m_size[2];
    logic [31:0] m_addr[2];
    logic [63:0] m_wdata[2], m_rdata[2];
    logic [63:0] exp_q[$];

    int tests = 0;
    int fails = 0;
    logic chk_en = 1'b0;
    int stall_cnt = 0;

    task automatic chk(input string nm, input int i, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s dut%0d: got %h expected %h at %0t", nm, i, act, exp, $time);
        end
    endtask

    // Compare process: every cycle, both instances against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 2; i++) begin
                chk("req",       i, 64'(o_req[i]),   64'(m_req[i]));
                chk("stall",     i, 64'(o_stall[i]), 64'(m_stall[i]));
                chk("bad_wen",   i, 64'(o_bad[i]),   64'(m_bad[i]));
                chk("wr",        i, 64'(o_wr[i]),    64'(m_wr[i]));
                chk("size",      i, 64'(o_size[i]),  64'(m_size[i]));
                chk("addr",      i, 64'(o_addr[i]),  64'(m_addr[i]));
                chk("wdata",     i, o_wdata[i],      m_wdata[i]);
                chk("cpu_rdata", i, o_rdata[i],      m_rdata[i]);
            end
            if (o_stall[sel]) stall_cnt++;
        end
    end

    // Reference mapping from byte enables to bus size/address.
    task automatic ref_map(input logic [7:0] w, input int bew, input logic [31:0] a,
                           output logic legal, output logic [1:0] sz, output logic [31:0] ba);
        int          n;
        logic [7:0]  run;
        logic [31:0] base;
        n     = $countones(w);
        legal = 1'b0;
        sz    = 2'd0;
        base  = (a / 32'(bew)) * 32'(bew);
        ba    = a;
        if (n == 0) begin
            legal = 1'b1;
            sz    = (bew == 8) ? 2'd3 : 2'd2;
            ba    = base;
        end else if ((n == 1 || n == 2 || n == 4 || n == 8) && n <= bew) begin
            run = 8'((9'd1 << n) - 9'd1);
            for (int k = 0; k < bew; k += n) begin
                if (w == (run << k)) begin
                    legal = 1'b1;
                    case (n)
                        1:       sz = 2'd0;
                        2:       sz = 2'd1;
                        4:       sz = 2'd2;
                        default: sz = 2'd3;
                    endcase
                    ba = base + 32'(k);
                end
            end
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_req[i] = 0; m_stall[i] = 0; m_bad[i] = 0; m_wr[i] = 0;
            m_size[i] = 0; m_addr[i] = 0; m_wdata[i] = 0; m_rdata[i] = 0;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        en = 0; aok = 0; dok = 0; ls = 0;
        m_stall[sel] = 0; m_bad[sel] = 0;
        repeat (n) step();
    endtask

    // One pipeline slot: addr_ok arrives after a extra req cycles, data_ok d
    // cycles later (d=0: together with addr_ok), longest_stall held hold cycles in DONE.
    task automatic do_access(input logic s, input logic [7:0] w, input logic [31:0] a,
                             input logic [63:0] wd, input int aw, input int dw,
                             input int hold, input logic [63:0] rd_in);
        logic        legal;
        logic [1:0]  sz;
        logic [31:0] ba;
        int          bew;
        logic [7:0]  wm;
        logic [63:0] rd, wdm;
        bew = s ? 8 : 4;
        wm  = s ? w : {4'd0, w[3:0]};
        rd  = s ? rd_in : {32'd0, rd_in[31:0]};
        wdm = s ? wd : {32'd0, wd[31:0]};
        ref_map(wm, bew, a, legal, sz, ba);
        sel = s; en = 1; wen = wm; caddr = a; cwdata = wd; ls = 0; aok = 0; dok = 0;
        brdata = {$urandom, $urandom};
        stall_cnt = 0;
        m_stall[s] = legal; m_bad[s] = !legal; m_req[s] = 0;
        step();
        if (!legal) begin
            en = 0; m_bad[s] = 0; m_stall[s] = 0;
            return;
        end
        m_wr[s] = (wm != 0); m_size[s] = sz; m_addr[s] = ba; m_wdata[s] = wdm;
        m_req[s] = 1; m_stall[s] = 1; m_bad[s] = 0;
        for (int i = 0; i <= aw; i++) begin
            wen = 8'($urandom); caddr = $urandom;
            aok = (i == aw); dok = (i == aw) && (dw == 0);
            brdata = (i == aw && dw == 0) ? rd : {$urandom, $urandom};
            step();
        end
        m_req[s] = 0;
        for (int j = 1; j <= dw; j++) begin
            aok = 1'($urandom); dok = (j == dw);
            brdata = (j == dw) ? rd : {$urandom, $urandom};
            step();
        end
        m_rdata[s] = rd; m_stall[s] = 0;
        exp_q.push_back(rd);
        chk("resp", int'(s), o_rdata[s], exp_q.pop_front());
        for (int h = 0; h <= hold; h++) begin
            ls = (h < hold); aok = 1'($urandom); dok = 1'($urandom);
            wen = wm; caddr = a; brdata = {$urandom, $urandom};
            step();
        end
        en = 0; ls = 0; aok = 0; dok = 0;
    endtask

    logic        p_legal;
    logic [1:0]  p_sz;
    logic [31:0] p_ba;
    logic [7:0]  legal_w32[6] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h03, 8'h0C};

    initial begin
        sel = 0; en = 0; wen = 0; caddr = 0; cwdata = 0; ls = 0; aok = 0; dok = 0;
        brdata = 0; rst = 1;
        model_reset();

        // Hand-computed pins on the reference mapping.
        ref_map(8'h00, 4, 32'h1000_0004, p_legal, p_sz, p_ba);
        chk("pin_rd32_size", 0, 64'(p_sz), 64'd2);
        chk("pin_rd32_addr", 0, 64'(p_ba), 64'h1000_0004);
        ref_map(8'h0C, 4, 32'h200, p_legal, p_sz, p_ba);
        chk("pin_wr1100", 0, {61'd0, p_legal, p_sz}, 64'h5);
        chk("pin_wr1100_addr", 0, 64'(p_ba), 64'h202);
        ref_map(8'h02, 4, 32'h200, p_legal, p_sz, p_ba);
        chk("pin_wr0010", 0, {29'd0, p_ba, p_legal, p_sz}, {29'd0, 32'h201, 3'b100});
        ref_map(8'h05, 4, 32'h200, p_legal, p_sz, p_ba);
        chk("pin_wr0101_illegal", 0, 64'(p_legal), 64'd0);
        ref_map(8'hF0, 8, 32'h100, p_legal, p_sz, p_ba);
        chk("pin_wrF0_64", 1, {29'd0, p_ba, p_legal, p_sz}, {29'd0, 32'h104, 3'b110});
        ref_map(8'h00, 8, 32'h10C, p_legal, p_sz, p_ba);
        chk("pin_rd64", 1, {29'd0, p_ba, p_legal, p_sz}, {29'd0, 32'h108, 3'b111});

        step();
        chk_en = 1;
        step(); step();
        rst = 0;
        idle(2);

        // Read with addr_ok in the 2nd req cycle and data_ok 3 cycles later.
        do_access(0, 8'h00, 32'h1000_0004, 64'd0, 1, 3, 0, 64'hDEAD_BEEF);
        chk("stall_len_read", 0, 64'(stall_cnt), 64'd6);
        chk("rdata_deadbeef", 0, o_rdata[0], 64'hDEAD_BEEF);
        do_access(0, 8'h0C, 32'h200, 64'hA5A5_1234, 0, 1, 0, 64'h0);
        do_access(0, 8'h02, 32'h200, 64'h0000_7700, 2, 2, 0, 64'h0);
        // Address and data accepted together.
        do_access(0, 8'h00, 32'h40, 64'd0, 0, 0, 0, 64'h1357_9BDF);
        chk("stall_len_fast", 0, 64'(stall_cnt), 64'd2);
        // Frozen pipeline keeps the response and never re-issues.
        do_access(0, 8'h00, 32'h80, 64'd0, 1, 1, 4, 64'hCAFE_F00D);
        do_access(0, 8'h0F, 32'h84, 64'h0BAD_CAFE, 0, 1, 0, 64'h0);
        chk("stall_after_hold", 0, 64'(stall_cnt), 64'd3);
        do_access(0, 8'h05, 32'h200, 64'd0, 0, 0, 0, 64'h0);
        idle(2);
        do_access(1, 8'hF0, 32'h100, 64'h1122_3344_5566_7788, 1, 2, 1, 64'h0);
        do_access(1, 8'h00, 32'h10C, 64'd0, 0, 0, 0, 64'h0123_4567_89AB_CDEF);

        // Randomized traffic on both widths.
        for (int t = 0; t < 150; t++) begin
            logic        s;
            logic [7:0]  w;
            int          r;
            s = 1'($urandom);
            r = $urandom_range(0, 9);
            if (r < 5)      w = 8'h00;
            else if (r < 8) w = s ? (8'h01 << $urandom_range(0, 7)) | 8'h00 : legal_w32[$urandom_range(0, 5)];
            else            w = 8'($urandom);
            if (s && r == 7) w = ($urandom_range(0, 1) == 1) ? 8'hFF : 8'h0F;
            do_access(s, w, $urandom, {$urandom, $urandom}, $urandom_range(0, 3),
                      $urandom_range(0, 3), $urandom_range(0, 3), {$urandom, $urandom});
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
        end

        // Reset while waiting for data; a late data_ok must be ignored.
        sel = 1; en = 1; wen = 8'h00; caddr = 32'h2000; ls = 0; aok = 0; dok = 0;
        m_stall[1] = 1; m_bad[1] = 0;
        step();
        m_wr[1] = 0; m_size[1] = 2'd3; m_addr[1] = 32'h2000; m_wdata[1] = cwdata;
        m_req[1] = 1; aok = 1;
        step();
        m_req[1] = 0; aok = 0; rst = 1;
        step();
        model_reset();
        rst = 0; en = 0; dok = 1; brdata = 64'hFFFF_EEEE_DDDD_CCCC;
        step();
        dok = 0;
        idle(3);
        chk("rst_rdata", 1, o_rdata[1], 64'd0);
        chk("rst_req", 1, 64'(o_req[1]), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
